// File: rtl/uart_tx_buf_if.sv
// Byte-write and serial-line signals of the buffered UART transmitter.
// The slave modport is the transmitter side; master is the producer side.
interface uart_tx_buf_if;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_full;
    logic       tx_empty;
    logic [3:0] fifo_count;
    logic       tx_drop;
    logic       uart_tx;
    logic       tx_busy;
    logic       tx_irq;

    modport master (
        output tx_data, tx_wr,
        input  tx_full, tx_empty, fifo_count, tx_drop, uart_tx, tx_busy, tx_irq
    );

    modport slave (
        input  tx_data, tx_wr,
        output tx_full, tx_empty, fifo_count, tx_drop, uart_tx, tx_busy, tx_irq
    );
endinterface

// File: rtl/uart_tx_buf.sv
// 8N1 UART transmitter fed by an 8-entry byte FIFO.
// One idle cycle separates frames; the line register lags the FSM state by one cycle.
module uart_tx_buf #(
    parameter int unsigned clk_freq = 100000000,
    parameter int unsigned baud     = 115200
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    uart_tx_buf_if.slave   bus
);

    localparam int unsigned BIT_TICKS = clk_freq / baud;
    localparam int unsigned TickW     = $clog2(BIT_TICKS);
    localparam logic [TickW-1:0] TickMax = TickW'(BIT_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             line_q, line_d;
    logic             tick_done;

    logic [7:0] mem_q [8];
    logic [2:0] wr_ptr_q, rd_ptr_q;
    logic [3:0] count_q, count_d;
    logic       full_q, empty_q, drop_q;
    logic       push, pop;

    // A full FIFO rejects writes even when a pop frees a slot in the same cycle.
    assign push      = bus.tx_wr & ~full_q;
    assign pop       = (state_q == StIdle) & ~empty_q;
    assign count_d   = count_q + 4'(push) - 4'(pop);
    assign tick_done = (tick_q == TickMax);

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.tx_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            drop_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 3'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 3'd1;
            count_q <= count_d;
            full_q  <= (count_d == 4'd8);
            empty_q <= (count_d == 4'd0);
            drop_q  <= bus.tx_wr & full_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            tick_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        line_d  = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (!empty_q) begin
                    shift_d = mem_q[rd_ptr_q];
                    state_d = StStart;
                    tick_d  = '0;
                    idx_d   = '0;
                end
            end
            StStart: begin
                line_d = 1'b0;
                if (tick_done) begin
                    state_d = StData;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            StData: begin
                line_d = shift_q[idx_q];
                if (tick_done) begin
                    tick_d = '0;
                    if (idx_q == 3'd7) state_d = StStop;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            StStop: begin
                if (tick_done) begin
                    state_d = StIdle;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.tx_full    = full_q;
    assign bus.tx_empty   = empty_q;
    assign bus.fifo_count = count_q;
    assign bus.tx_drop    = drop_q;
    assign bus.uart_tx    = line_q;
    assign bus.tx_busy    = (state_q != StIdle);
    assign bus.tx_irq     = (state_q == StStop) && tick_done;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench: accepted bytes are queued, a line receiver pops and compares each frame.
module tb_uart_tx_buf;

    logic sys_clk;
    logic sys_rst_n;
    uart_tx_buf_if bus ();

    uart_tx_buf #(
        .clk_freq (1000),
        .baud     (100)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned irq_cnt  = 0;
    int unsigned drop_cnt = 0;
    int unsigned rx_frames = 0;
    logic [7:0]  exp_q[$];
    int unsigned starts[$];

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial forever begin
        @(posedge sys_clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line receiver: detection lands half a cycle into the start bit, samples near mid-bit.
    initial begin
        bit         rx_active = 1'b0;
        int         rx_cnt    = 0;
        logic [7:0] rx_byte   = '0;
        logic [7:0] exp_byte;
        logic       irq_prev  = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (bus.uart_tx == 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                    starts.push_back(cyc);
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % 10 == 4) begin
                    if (rx_cnt / 10 == 0) begin
                        check("start bit", 32'(bus.uart_tx), 32'd0);
                    end else if (rx_cnt / 10 <= 8) begin
                        rx_byte[rx_cnt / 10 - 1] = bus.uart_tx;
                    end else begin
                        check("stop bit", 32'(bus.uart_tx), 32'd1);
                        check("frame expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            exp_byte = exp_q.pop_front();
                            check("rx byte", 32'(rx_byte), 32'(exp_byte));
                        end
                        rx_frames++;
                        rx_active = 1'b0;
                    end
                end
            end
            if (bus.tx_irq) begin
                irq_cnt++;
                check("irq single cycle", 32'(irq_prev), 32'd0);
                check("irq during stop", 32'(bus.uart_tx), 32'd1);
            end
            irq_prev = bus.tx_irq;
            if (bus.tx_drop) drop_cnt++;
        end
    end

    // Called at a negedge; the write is sampled on the next rising edge.
    task automatic wr(input logic [7:0] d);
        bus.tx_wr   = 1'b1;
        bus.tx_data = d;
        @(negedge sys_clk);
        bus.tx_wr   = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        bit done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge sys_clk);
            if (!bus.tx_busy && bus.tx_empty) done = 1'b1;
        end
        check("idle reached", 32'(done), 32'd1);
        repeat (3) @(negedge sys_clk);
    endtask

    initial begin
        int unsigned irq_base, drop_base, n_starts;
        bit          seen;
        sys_rst_n   = 1'b0;
        bus.tx_wr   = 1'b0;
        bus.tx_data = 8'h00;
        repeat (2) @(negedge sys_clk);
        check("rst empty", 32'(bus.tx_empty), 32'd1);
        check("rst full", 32'(bus.tx_full), 32'd0);
        check("rst count", 32'(bus.fifo_count), 32'd0);
        check("rst line", 32'(bus.uart_tx), 32'd1);
        check("rst busy", 32'(bus.tx_busy), 32'd0);
        check("rst irq", 32'(bus.tx_irq), 32'd0);
        check("rst drop", 32'(bus.tx_drop), 32'd0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Single 0xA5 frame: latency and interrupt position.
        exp_q.push_back(8'hA5);
        wr(8'hA5);
        check("count after write", 32'(bus.fifo_count), 32'd1);
        @(negedge sys_clk);
        check("line high at pop", 32'(bus.uart_tx), 32'd1);
        check("busy after pop", 32'(bus.tx_busy), 32'd1);
        check("empty after pop", 32'(bus.tx_empty), 32'd1);
        @(negedge sys_clk);
        check("line low at N+2", 32'(bus.uart_tx), 32'd0);
        repeat (97) @(negedge sys_clk);
        check("irq before cycle 100", 32'(bus.tx_irq), 32'd0);
        @(negedge sys_clk);
        check("irq at cycle 100", 32'(bus.tx_irq), 32'd1);
        @(negedge sys_clk);
        check("irq after cycle 100", 32'(bus.tx_irq), 32'd0);
        check("idle after frame", 32'(bus.tx_busy), 32'd0);
        wait_idle(200);
        check("irq count A5", irq_cnt, 32'd1);

        // Burst of three: ordering and one-cycle gap between frames.
        starts.delete();
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(8'(i));
            wr(8'(i));
        end
        check("count after burst", 32'(bus.fifo_count), 32'd2);
        wait_idle(500);
        check("burst frames started", starts.size(), 32'd3);
        if (starts.size() == 3) begin
            check("frame spacing 1-2", starts[1] - starts[0], 32'd101);
            check("frame spacing 2-3", starts[2] - starts[1], 32'd101);
        end
        check("irq count burst", irq_cnt, 32'd4);
        check("empty after burst", 32'(bus.tx_empty), 32'd1);

        // Fill to full during a frame, then overflow.
        drop_base = drop_cnt;
        exp_q.push_back(8'h10);
        wr(8'h10);
        repeat (3) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'(8'h20 + i));
            wr(8'(8'h20 + i));
        end
        check("count full", 32'(bus.fifo_count), 32'd8);
        check("full flag", 32'(bus.tx_full), 32'd1);
        check("empty when full", 32'(bus.tx_empty), 32'd0);
        check("no drop yet", 32'(bus.tx_drop), 32'd0);
        wr(8'h28);
        check("drop on ninth", 32'(bus.tx_drop), 32'd1);
        check("count stays 8", 32'(bus.fifo_count), 32'd8);
        @(negedge sys_clk);
        check("drop one cycle", 32'(bus.tx_drop), 32'd0);

        // Write while full in the cycle the FSM pops.
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge sys_clk);
            if (!bus.tx_busy) seen = 1'b1;
        end
        check("reached idle gap", 32'(seen), 32'd1);
        check("full at pop cycle", 32'(bus.tx_full), 32'd1);
        wr(8'h99);
        check("drop with pop", 32'(bus.tx_drop), 32'd1);
        check("count 7 after pop", 32'(bus.fifo_count), 32'd7);
        check("not full after pop", 32'(bus.tx_full), 32'd0);
        wait_idle(1200);
        check("drop total", drop_cnt - drop_base, 32'd2);
        check("irq count overflow", irq_cnt, 32'd13);

        // Reset mid-frame with two bytes queued.
        irq_base = irq_cnt;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'(8'h55 + 8'h11 * i));
            wr(8'(8'h55 + 8'h11 * i));
        end
        check("two queued", 32'(bus.fifo_count), 32'd2);
        repeat (42) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check("abort line high", 32'(bus.uart_tx), 32'd1);
        check("abort empty", 32'(bus.tx_empty), 32'd1);
        check("abort count", 32'(bus.fifo_count), 32'd0);
        check("abort busy", 32'(bus.tx_busy), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        n_starts = starts.size();
        repeat (300) @(negedge sys_clk);
        check("no frame after reset", starts.size() - n_starts, 32'd0);
        check("no irq after reset", irq_cnt - irq_base, 32'd0);
        check("idle after reset", 32'(bus.tx_busy), 32'd0);

        // Throttled stream of 20 bytes across pointer wrap.
        drop_base = drop_cnt;
        for (int i = 0; i < 20; i++) begin
            seen = 1'b0;
            for (int j = 0; j < 2000 && !seen; j++) begin
                if (!bus.tx_full) seen = 1'b1;
                else @(negedge sys_clk);
            end
            check("stream slot", 32'(seen), 32'd1);
            exp_q.push_back(8'(i));
            wr(8'(i));
            repeat (3) @(negedge sys_clk);
        end
        wait_idle(3000);
        check("stream drops", drop_cnt - drop_base, 32'd0);
        check("scoreboard drained", exp_q.size(), 32'd0);
        check("frames received", rx_frames, 32'd33);
        check("irq total", irq_cnt, 32'd33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
